store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write buffer directly upstream of the data memory.
//  - Accepts 64-bit doubleword stores from the EX/MEM stage and holds them in an in-order FIFO.
//  - Drains one store per cycle into the data memory write port.
//  - Forwards buffered data to loads whose address exactly matches a buffered store.
//  - Flags loads that partially overlap a buffered store, so the pipeline stalls until that store drains.
// PARAMETERS
//  DEPTH   4   entries; power of two, >=2
//  ADDR_W  64  byte address width
//  DATA_W  64  store data width (8 bytes, little-endian)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high; clears all state
//  st_valid     in   1       store request from EX/MEM
//  st_addr      in   ADDR_W  store byte address
//  st_data      in   DATA_W  store data
//  st_ready     out  1       store accepted this cycle when st_valid&st_ready
//  ld_valid     in   1       load lookup qualifier
//  ld_addr      in   ADDR_W  load byte address
//  ld_hit       out  1       youngest exact-address match found (combinational)
//  ld_data      out  DATA_W  forwarded data; 0 when !ld_hit
//  ld_conflict  out  1       load overlaps a buffered entry with unequal address
//  drain_en     in   1       data memory write port free this cycle
//  mem_write    out  1       MemWrite to data memory
//  mem_addr     out  ADDR_W  Mem_Addr to data memory (head entry)
//  mem_wdata    out  DATA_W  WriteData to data memory (head entry)
//  sb_empty     out  1       count==0 (used for fence/halt)
//  sb_count     out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset (async): rd_ptr, wr_ptr and count go to 0; every entry is invalidated.
//    Outputs: mem_write=0, mem_addr=0, mem_wdata=0, ld_hit=0, ld_data=0, ld_conflict=0, sb_empty=1, st_ready=1.
//    Stores still buffered when reset asserts are discarded, not written.
//  - Push: on posedge with st_valid&st_ready, write the entry at wr_ptr, then wr_ptr+1 mod DEPTH.
//  - st_ready = (count<DEPTH). It is not relaxed by a same-cycle pop.
//  - Drain: mem_write = (count!=0) & drain_en. mem_addr/mem_wdata always show the head entry (0 when empty).
//  - Pop occurs at the same posedge on which the data memory samples the write: rd_ptr+1 mod DEPTH.
//  - Simultaneous push+pop: count is unchanged; both pointers advance.
//  - A store pushed into an empty buffer drains no earlier than the next cycle. Minimum store-to-memory latency is 1 cycle.
//  - Forwarding: ld_hit=ld_valid & (some valid entry addr==ld_addr).
//    The youngest matching entry (nearest wr_ptr-1) supplies ld_data.
//    The head entry still forwards during its drain cycle.
//    A store being pushed in the same cycle is NOT forwarded.
//  - Overlap: ld_conflict=ld_valid & (some valid entry has addr!=ld_addr and |addr-ld_addr|<8).
//    The compare is a 64-bit subtract, with no wrap at the address-space top.
//    ld_hit and ld_conflict may both be 1; the pipeline treats conflict as a stall.
//  - Pointers wrap mod DEPTH. Full/empty are taken from count, never from pointer equality.
// CONFIGURATION
//  SB_COALESCE_EN defined:
//  - A store whose st_addr equals the youngest entry's address overwrites that entry's data; nothing is allocated.
//  - Exception: no merge if that entry is the head and is popping this cycle; the store then allocates normally.
//  - st_ready = (count<DEPTH) | merge_hit, so a merge is accepted when full.
//  SB_COALESCE_EN undefined: every accepted store allocates a new entry.
// STRUCTURE
//  - Shared package mem_pkg:
//    - DWORD_BYTES=8
//    - typedef sb_entry_t {addr[ADDR_W], data[DATA_W]}
//    - function dword_overlap(a,b) returning |a-b|<DWORD_BYTES
//  - Sub-module sb_entry_cmp: per-entry exact/overlap comparator, instantiated DEPTH times.
//  - Youngest-match priority select stays in store_buffer.
// TESTING
//  1. Reset mid-drain:
//     - Stimulus: push 3 stores, drain_en=1, assert reset in cycle 2.
//     - Response: mem_write=0 immediately; sb_count=0; remaining stores are never written.
//  2. Fill/full:
//     - Stimulus: drain_en=0, push 4 stores (addrs 0,8,16,24), then a 5th.
//     - Response: st_ready=0 and the 5th is held off.
//     - Then drain_en=1: writes in order 0,8,16,24 on consecutive cycles; sb_empty=1 afterwards.
//  3. Forwarding:
//     - Stimulus: push A@0x10=0x1111, B@0x10=0x2222, drain_en=0, ld_addr=0x10.
//     - Response: ld_hit=1, ld_data=0x2222.
//     - Stimulus: ld_addr=0x18.
//     - Response: ld_hit=0, ld_conflict=0.
//  4. Overlap:
//     - Stimulus: buffered store @0x20, ld_addr=0x24.
//     - Response: ld_conflict=1, ld_hit=0.
//     - Stimulus: ld_addr=0x28.
//     - Response: ld_conflict=0.
//  5. Wrap + simultaneous push/pop:
//     - Stimulus: DEPTH=4, 10 stores, continuous drain_en=1, one push per cycle.
//     - Response: count stays 1; pointers wrap; memory image matches all 10 in order.
//  6. SB_COALESCE_EN:
//     - Stimulus: full buffer, youngest @0x30, push 0x30=0xABCD.
//     - Response: accepted; count stays 4; the drained value for 0x30 is 0xABCD.
//     - Same stimulus without the macro: st_ready=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-side definitions: doubleword size, store-buffer entry
// layout and the doubleword overlap test used by the store buffer.
package mem_pkg;

    localparam int DWORD_BYTES = 8;
    localparam int SB_ADDR_W   = 64;
    localparam int SB_DATA_W   = 64;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    // True when the two byte addresses are less than one doubleword apart.
    // The distance is taken as a plain magnitude, so no wrap-around at the
    // top of the address space is considered.
    function automatic logic dword_overlap(input logic [SB_ADDR_W-1:0] a,
                                           input logic [SB_ADDR_W-1:0] b);
        logic [SB_ADDR_W-1:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return diff < SB_ADDR_W'(DWORD_BYTES);
    endfunction

endpackage

// File: rtl/sb_entry_cmp.sv
// Per-entry load comparator for the store buffer: reports an exact address
// match and a partial (different address, same doubleword window) overlap.
module sb_entry_cmp
    import mem_pkg::*;
(
    input  logic                 valid,
    input  logic [SB_ADDR_W-1:0] entry_addr,
    input  logic [SB_ADDR_W-1:0] ld_addr,
    output logic                 exact,
    output logic                 overlap
);

    // Both flags are gated by the entry valid bit so stale slots never match.
    always_comb begin
        exact   = valid & (entry_addr == ld_addr);
        overlap = valid & (entry_addr != ld_addr) & dword_overlap(entry_addr, ld_addr);
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of the data memory. Stores are held in
// an in-order FIFO, drained one per cycle, and forwarded to exact-match loads;
// partially overlapping loads raise ld_conflict so the pipeline stalls.
// Optional feature: define SB_COALESCE_EN to merge a store into the youngest
// entry when the addresses are equal.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_conflict,
    input  logic                     drain_en,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     young_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic              merge;
    logic [DEPTH-1:0]  exact;
    logic [DEPTH-1:0]  overlap;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`ifdef SB_COALESCE_EN
    logic              merge_cand;
`endif

    assign young_ptr = wr_ptr - PW'(1);

    // Push/pop/merge decisions; a same-cycle pop never frees a slot for a push.
    always_comb begin
        pop = (count != '0) & drain_en;
`ifdef SB_COALESCE_EN
        merge_cand = (count != '0) & (entries[young_ptr].addr == st_addr)
                   & ~(pop & (count == CW'(1)));
        st_ready   = (count < CW'(DEPTH)) | merge_cand;
        merge      = st_valid & merge_cand;
`else
        st_ready   = (count < CW'(DEPTH));
        merge      = 1'b0;
`endif
        push = st_valid & st_ready & ~merge;
    end

    // Head entry is presented to the data memory; zero when nothing is buffered.
    always_comb begin
        mem_write = pop;
        mem_addr  = '0;
        mem_wdata = '0;
        if (count != '0) begin
            mem_addr  = entries[rd_ptr].addr;
            mem_wdata = entries[rd_ptr].data;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        sb_entry_cmp u_cmp (
            .valid      (valid[i]),
            .entry_addr (entries[i].addr),
            .ld_addr    (ld_addr),
            .exact      (exact[i]),
            .overlap    (overlap[i])
        );
    end

    // Walk oldest to youngest so the last exact match (the youngest) wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (exact[idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx].data;
            end
        end
        ld_hit      = ld_valid & fwd_hit;
        ld_data     = ld_hit ? fwd_data : '0;
        ld_conflict = ld_valid & (|overlap);
    end

    // FIFO state: entries, valid bits, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[wr_ptr].addr <= st_addr;
                entries[wr_ptr].data <= st_data;
                valid[wr_ptr]        <= 1'b1;
                wr_ptr               <= wr_ptr + PW'(1);
            end
            if (merge) begin
                entries[young_ptr].data <= st_data;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign sb_count = count;
    assign sb_empty = (count == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: accepted stores are queued as expected
// memory writes and a monitor compares every mem_write against the queue.
// Status outputs (ready, count, forwarding, conflict) are checked directly.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic [63:0] st_addr = '0;
    logic [63:0] st_data = '0;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [63:0] ld_addr = '0;
    logic        ld_hit;
    logic [63:0] ld_data;
    logic        ld_conflict;
    logic        drain_en = 1'b0;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        sb_empty;
    logic [2:0]  sb_count;

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    store_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_hit      (ld_hit),
        .ld_data     (ld_data),
        .ld_conflict (ld_conflict),
        .drain_en    (drain_en),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .sb_empty    (sb_empty),
        .sb_count    (sb_count)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; an accepted store is queued after the edge.
    task automatic applyStimulus(input logic sv, input logic [63:0] a, input logic [63:0] d,
                                 input logic drn, input logic exp_accept);
        logic rdy;
        st_valid = sv;
        st_addr  = a;
        st_data  = d;
        drain_en = drn;
        @(negedge clk);
        rdy = st_ready;
        if (sv) checkOutput("st_ready", {63'b0, rdy}, {63'b0, exp_accept});
        @(posedge clk);
        #1;
        if (sv && exp_accept) expq.push_back('{a: a, d: d});
        st_valid = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        st_valid = 1'b0;
        drain_en = 1'b0;
        expq.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drainAll(input int cycles);
        drain_en = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
        end
        #1;
        checkOutput("empty_after_drain", {63'b0, sb_empty}, 64'd1);
        drain_en = 1'b0;
    endtask

    // Monitor: every memory write must match the oldest expected store.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_write === 1'b1) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write at %0t",
                             mem_addr, mem_wdata, $time);
                end else begin
                    e = expq.pop_front();
                    checkOutput("mem_addr", mem_addr, e.a);
                    checkOutput("mem_wdata", mem_wdata, e.d);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        ld_valid = 1'b1;
        ld_addr  = 64'h0;
        #2;
        checkOutput("rst_mem_write", {63'b0, mem_write}, 64'd0);
        checkOutput("rst_mem_addr", mem_addr, 64'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 64'd0);
        checkOutput("rst_ld_hit", {63'b0, ld_hit}, 64'd0);
        checkOutput("rst_ld_data", ld_data, 64'd0);
        checkOutput("rst_ld_conflict", {63'b0, ld_conflict}, 64'd0);
        checkOutput("rst_sb_empty", {63'b0, sb_empty}, 64'd1);
        checkOutput("rst_st_ready", {63'b0, st_ready}, 64'd1);
        checkOutput("rst_sb_count", {61'b0, sb_count}, 64'd0);
        ld_valid = 1'b0;
        doReset();

        // 1. Reset mid-drain: third store is discarded
        applyStimulus(1'b1, 64'h100, 64'hA0, 1'b1, 1'b1);
        applyStimulus(1'b1, 64'h108, 64'hA1, 1'b1, 1'b1);
        applyStimulus(1'b1, 64'h110, 64'hA2, 1'b1, 1'b1);
        checkOutput("t1_write_before_reset", {63'b0, mem_write}, 64'd1);
        reset = 1'b1;
        expq.delete();
        #1;
        checkOutput("t1_mem_write_in_reset", {63'b0, mem_write}, 64'd0);
        checkOutput("t1_count_in_reset", {61'b0, sb_count}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t1_count_after", {61'b0, sb_count}, 64'd0);
        drain_en = 1'b0;

        // 2. Fill to full, hold off the fifth store, then drain in order
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 64'(i * 8), 64'h200 + 64'(i), 1'b0, 1'b1);
        end
        checkOutput("t2_count_full", {61'b0, sb_count}, 64'd4);
        checkOutput("t2_ready_full", {63'b0, st_ready}, 64'd0);
        applyStimulus(1'b1, 64'd32, 64'h2FF, 1'b0, 1'b0);
        checkOutput("t2_count_held", {61'b0, sb_count}, 64'd4);
        drainAll(4);

        // 3. Forwarding from the youngest match
        doReset();
        applyStimulus(1'b1, 64'h10, 64'h1111, 1'b0, 1'b1);
`ifdef SB_COALESCE_EN
        applyStimulus(1'b1, 64'h10, 64'h2222, 1'b0, 1'b1);
        expq.pop_back();
        expq[expq.size()-1].d = 64'h2222;
`else
        applyStimulus(1'b1, 64'h10, 64'h2222, 1'b0, 1'b1);
`endif
        ld_valid = 1'b1;
        ld_addr  = 64'h10;
        #1;
        checkOutput("t3_hit", {63'b0, ld_hit}, 64'd1);
        checkOutput("t3_data", ld_data, 64'h2222);
        checkOutput("t3_no_conflict", {63'b0, ld_conflict}, 64'd0);
        ld_addr = 64'h18;
        #1;
        checkOutput("t3_miss_hit", {63'b0, ld_hit}, 64'd0);
        checkOutput("t3_miss_conflict", {63'b0, ld_conflict}, 64'd0);
        checkOutput("t3_miss_data", ld_data, 64'd0);
        ld_addr  = 64'h40;
        st_valid = 1'b1;
        st_addr  = 64'h40;
        st_data  = 64'h4444;
        #1;
        checkOutput("t3_same_cycle_store", {63'b0, ld_hit}, 64'd0);
        st_valid = 1'b0;
        ld_addr  = 64'h10;
        ld_valid = 1'b0;
        #1;
        checkOutput("t3_ld_valid_low", {63'b0, ld_hit}, 64'd0);
        @(posedge clk);
        #1;
        drainAll(2);

        // 4. Partial overlap detection
        doReset();
        applyStimulus(1'b1, 64'h20, 64'h55, 1'b0, 1'b1);
        ld_valid = 1'b1;
        ld_addr  = 64'h24;
        #1;
        checkOutput("t4_conflict_24", {63'b0, ld_conflict}, 64'd1);
        checkOutput("t4_hit_24", {63'b0, ld_hit}, 64'd0);
        ld_addr = 64'h28;
        #1;
        checkOutput("t4_conflict_28", {63'b0, ld_conflict}, 64'd0);
        ld_addr = 64'h19;
        #1;
        checkOutput("t4_conflict_19", {63'b0, ld_conflict}, 64'd1);
        ld_addr = 64'h18;
        #1;
        checkOutput("t4_conflict_18", {63'b0, ld_conflict}, 64'd0);
        ld_addr = 64'h20;
        #1;
        checkOutput("t4_hit_20", {63'b0, ld_hit}, 64'd1);
        checkOutput("t4_exact_no_conflict", {63'b0, ld_conflict}, 64'd0);
        ld_valid = 1'b0;
        drainAll(1);

        // 5. Wrap-around with a push and a pop every cycle
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 64'h1000 + 64'(i * 8), 64'hC00 + 64'(i), 1'b1, 1'b1);
            checkOutput("t5_count", {61'b0, sb_count}, 64'd1);
        end
        drainAll(1);

        // 6. Store to the youngest address while full
        doReset();
        applyStimulus(1'b1, 64'h00, 64'h60, 1'b0, 1'b1);
        applyStimulus(1'b1, 64'h08, 64'h61, 1'b0, 1'b1);
        applyStimulus(1'b1, 64'h10, 64'h62, 1'b0, 1'b1);
        applyStimulus(1'b1, 64'h30, 64'h63, 1'b0, 1'b1);
`ifdef SB_COALESCE_EN
        applyStimulus(1'b1, 64'h30, 64'hABCD, 1'b0, 1'b1);
        expq.pop_back();
        expq[expq.size()-1].d = 64'hABCD;
`else
        applyStimulus(1'b1, 64'h30, 64'hABCD, 1'b0, 1'b0);
`endif
        checkOutput("t6_count", {61'b0, sb_count}, 64'd4);
        drainAll(4);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("writes_outstanding", 64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
